forwarding_hazard_unit: RTL
===========================

// Module: forwarding_hazard_unit
// PURPOSE
//  Pipelined forwarding-select and load-use hazard unit for the 5-stage MIPS core.
//  Successor to the 2-operand EX-stage forwarding logic: parametrised operand count and register address width.
//  Adds load-use stall/bubble generation with a configurable load latency, plus a same-cycle WB->ID bypass.
//  Sits beside the ID/EX pipeline register. Drives the EX operand muxes, stall (PC, IF_ID), flush_ex (ID_EX bubble).
// PARAMETERS
//  NUM_SRC   2  source operands per instruction (Rs, Rt, ...)
//  REG_AW    5  register-address width; register 0 is hardwired zero and is never forwarded
//  LOAD_LAT  1  stall cycles for a load-use hazard (1..3)
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               asynchronous, active-high reset
//  hold         in   1               global freeze (e.g. cache miss); all state holds
//  id_src       in   NUM_SRC*REG_AW  ID-stage source register numbers, operand i at [i*REG_AW +: REG_AW]
//  id_src_use   in   NUM_SRC         operand i is actually read by the ID instruction
//  ex_dest      in   REG_AW          ID_EX destination register
//  ex_regwrite  in   1               ID_EX RegWrite
//  ex_memread   in   1               ID_EX MemRead (instruction is a load)
//  mem_dest     in   REG_AW          EX_MEM destination register
//  mem_regwrite in   1               EX_MEM RegWrite
//  wb_dest      in   REG_AW          MEM_WB destination register
//  wb_regwrite  in   1               MEM_WB RegWrite
//  fwd_sel      out  NUM_SRC*2       registered EX mux select per operand: 00 regfile, 10 EX_MEM, 01 MEM_WB
//  id_bypass    out  NUM_SRC         combinational: operand i must take the WB write data in ID
//  stall        out  1               combinational: freeze PC and IF_ID this cycle
//  flush_ex     out  1               combinational: load a bubble into ID_EX at the next edge (== stall)
// BEHAVIOUR
//  Reset: fwd_sel=0, stall counter=0, state IDLE. stall, flush_ex and id_bypass are forced 0 while rst is high.
//  Match rule: hit(d, we, s, use) = we & use & (d != 0) & (d == s).
//  Pre-decode in ID, per operand i:
//   nxt_i = 2'b10 if hit(ex_dest, ex_regwrite & ~ex_memread, src_i)
//           else 2'b01 if hit(mem_dest, mem_regwrite, src_i)
//           else 2'b00.
//   The youngest producer wins. A load in EX never yields 10; load data is not available from EX_MEM.
//  Register update at posedge clk:
//   - If hold: fwd_sel holds.
//   - Else if stall: fwd_sel <= 0, because a bubble enters EX.
//   - Else: fwd_sel <= nxt.
//   fwd_sel therefore has 1-cycle latency and is valid for the instruction in EX.
//  id_bypass_i = hit(wb_dest, wb_regwrite, src_i) & ~hit(mem_dest, ...) & ~hit(ex_dest, ...).
//   This is the regfile write/read same-cycle case.
//  Load-use detect: lu = OR_i hit(ex_dest, ex_regwrite & ex_memread, src_i).
//  FSM states: IDLE, STALL.
//   - IDLE: stall = lu. If lu & ~hold & LOAD_LAT > 1: cnt <= LOAD_LAT-1, go to STALL.
//   - STALL: stall = 1. If ~hold: cnt <= cnt-1; when cnt reaches 1, go to IDLE on that edge.
//   - LOAD_LAT = 1: the FSM never leaves IDLE.
//   - During stall the ID instruction is re-decoded every cycle against the moving EX/MEM/WB contents.
//  hold has priority over everything sequential: fwd_sel, state and cnt are frozen. stall stays as computed.
//  Simultaneous EX and MEM hits on the same register select 10; simultaneous MEM and WB hits select 01.
//  An unused operand (id_src_use=0) never causes a forward, bypass or stall.
//  Reset asserted mid-stall: async return to IDLE and fwd_sel=0. After release, detection restarts from live inputs.
// STRUCTURE
//  Shared package mips_pkg:
//   - FWD_REGFILE=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
//   - REG_ZERO
//   - hazard state enum {HZ_IDLE, HZ_STALL}
//  One sub-module, fwd_src_decode: per-operand combinational hit/priority logic, generated NUM_SRC times.
//  The top level holds fwd_sel regs, the FSM/counter, and the OR-reduce for lu.
// TESTING
//  1. add $3 in EX (regwrite), ID reads $3 as src0 -> next cycle fwd_sel[1:0]=10; stall=0.
//  2. Writer of $5 in MEM, ID src1=$5 -> next cycle fwd_sel[3:2]=01. Writers of $5 in both EX and MEM -> 10.
//  3. lw $4 in EX, ID src0=$4, LOAD_LAT=1 -> stall=flush_ex=1 for exactly 1 cycle, fwd_sel=00 in the bubble cycle.
//     Next EX cycle: fwd_sel[1:0]=01.
//  4. LOAD_LAT=2, lw $4 then dependent -> stall high 2 cycles. hold pulsed in cycle 1 -> stall extends 1 cycle; fwd_sel frozen.
//  5. Dest=$0 with regwrite, or id_src_use=0 -> fwd_sel=00, id_bypass=0, stall=0. WB writes $7, ID reads $7 -> id_bypass=1.
//  6. rst asserted async during STALL -> fwd_sel=0, stall=0 immediately; after release with no hazard, stall stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_pkg                                                        |
// | Desc     : Shared constants and types for the 5-stage MIPS pipeline.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mips_pkg;

   // EX operand mux selects
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   // Register 0 reads as zero and is never a forwarding source
   localparam int REG_ZERO = 0;

   typedef enum logic [0:0] {
      HZ_IDLE  = 1'b0,
      HZ_STALL = 1'b1
   } hzState_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fwd_src_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_src_decode                                                  |
// | Desc     : Per-operand producer match, forward priority and load-use flag. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fwd_src_decode
   import mips_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic              srcUse,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic              wb_regwrite,
   output logic [1:0]        nxtSel,
   output logic              bypass,
   output logic              loadUse
);

   function automatic logic hit(
      input logic [REG_AW-1:0] d,
      input logic              we,
      input logic [REG_AW-1:0] s,
      input logic              srcUsed
   );
      hit = we & srcUsed & (d != REG_AW'(REG_ZERO)) & (d == s);
   endfunction

   logic w_exAluHit;
   logic w_exAnyHit;
   logic w_memHit;
   logic w_wbHit;

   // A load in EX has no result on EX_MEM yet, so it can only stall, not forward
   assign w_exAluHit = hit(ex_dest, ex_regwrite & ~ex_memread, src, srcUse);
   assign w_exAnyHit = hit(ex_dest, ex_regwrite, src, srcUse);
   assign w_memHit   = hit(mem_dest, mem_regwrite, src, srcUse);
   assign w_wbHit    = hit(wb_dest, wb_regwrite, src, srcUse);
   assign loadUse    = hit(ex_dest, ex_regwrite & ex_memread, src, srcUse);

   always_comb begin
      nxtSel = FWD_REGFILE;
      if (w_exAluHit) begin
         nxtSel = FWD_EXMEM;
      end else if (w_memHit) begin
         nxtSel = FWD_MEMWB;
      end
   end

   // Regfile write and read in the same cycle; a younger producer overrides it
   assign bypass = w_wbHit & ~w_memHit & ~w_exAnyHit;

endmodule : fwd_src_decode
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : forwarding_hazard_unit                                          |
// | Desc     : EX forwarding selects, WB->ID bypass and load-use stall FSM.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module forwarding_hazard_unit
   import mips_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hold,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_use,
   input  logic [REG_AW-1:0]         ex_dest,
   input  logic                      ex_regwrite,
   input  logic                      ex_memread,
   input  logic [REG_AW-1:0]         mem_dest,
   input  logic                      mem_regwrite,
   input  logic [REG_AW-1:0]         wb_dest,
   input  logic                      wb_regwrite,
   output logic [NUM_SRC*2-1:0]      fwd_sel,
   output logic [NUM_SRC-1:0]        id_bypass,
   output logic                      stall,
   output logic                      flush_ex
);

   localparam logic [1:0] c_STALL_INIT = 2'(LOAD_LAT - 1);

   logic [NUM_SRC*2-1:0] w_nxtSel;
   logic [NUM_SRC-1:0]   w_bypass;
   logic [NUM_SRC-1:0]   w_luVec;
   logic                 w_loadUse;
   logic                 w_stall;

   hzState_t             r_state;
   hzState_t             w_nextState;
   logic [1:0]           r_cnt;
   logic [1:0]           w_nextCnt;
   logic [NUM_SRC*2-1:0] r_fwdSel;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_decode #(
         .REG_AW (REG_AW)
      ) u_dec (
         .src          (id_src[i*REG_AW +: REG_AW]),
         .srcUse       (id_src_use[i]),
         .ex_dest      (ex_dest),
         .ex_regwrite  (ex_regwrite),
         .ex_memread   (ex_memread),
         .mem_dest     (mem_dest),
         .mem_regwrite (mem_regwrite),
         .wb_dest      (wb_dest),
         .wb_regwrite  (wb_regwrite),
         .nxtSel       (w_nxtSel[i*2 +: 2]),
         .bypass       (w_bypass[i]),
         .loadUse      (w_luVec[i])
      );
   end

   assign w_loadUse = |w_luVec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= HZ_IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // hold freezes the counter and state; cnt counts the remaining stall cycles
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      if (!hold) begin
         case (r_state)
            HZ_IDLE: begin
               if (w_loadUse && (LOAD_LAT > 1)) begin
                  w_nextState = HZ_STALL;
                  w_nextCnt   = c_STALL_INIT;
               end
            end
            HZ_STALL: begin
               w_nextCnt = r_cnt - 2'd1;
               if (r_cnt == 2'd1) begin
                  w_nextState = HZ_IDLE;
               end
            end
            default: begin
               w_nextState = HZ_IDLE;
               w_nextCnt   = 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      w_stall   = (r_state == HZ_STALL) | w_loadUse;
      stall     = w_stall & ~rst;
      flush_ex  = w_stall & ~rst;
      id_bypass = rst ? '0 : w_bypass;
   end

   // A stalled cycle pushes a bubble into EX, which must read the regfile path
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fwdSel <= '0;
      end else if (!hold) begin
         r_fwdSel <= w_stall ? '0 : w_nxtSel;
      end
   end

   assign fwd_sel = r_fwdSel;

endmodule : forwarding_hazard_unit
`default_nettype wire
